// File: rtl/spi_init_seq.sv
// Power-up register-init sequencer: waits a power-up delay, then walks a packed
// table issuing one SPI word per entry, with inline delay entries, finish timeout and restart.
module spi_init_seq #(
  parameter int unsigned                       DATA_WIDTH = 16,
  parameter int unsigned                       NUM_REGS   = 15,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]    INIT_TABLE = '0,
  parameter int unsigned                       DELAY_TIME = 10000,
  parameter int unsigned                       GAP_CYCLES = 1000,
  parameter int unsigned                       TIMEOUT    = 65535,
  parameter logic [7:0]                        DELAY_TAG  = 8'hFF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            restart,
  input  logic                            spi_finish,
  output logic                            spi_start,
  output logic [DATA_WIDTH-1:0]           spi_data,
  output logic [$clog2(NUM_REGS+1)-1:0]   reg_index,
  output logic                            busy,
  output logic                            config_done,
  output logic                            timeout_err
);

  localparam int unsigned DW      = DATA_WIDTH;
  localparam int unsigned IW      = $clog2(NUM_REGS + 1);
  localparam int unsigned DLY_W   = DATA_WIDTH - 8;
  localparam int unsigned MAX_DG  = (DELAY_TIME > GAP_CYCLES) ? DELAY_TIME : GAP_CYCLES;
  localparam int unsigned CFG_MAX = (MAX_DG > TIMEOUT) ? MAX_DG : TIMEOUT;
  localparam int unsigned CFG_W   = $clog2(CFG_MAX + 1);
  localparam int unsigned CW      = (CFG_W > DLY_W) ? CFG_W : DLY_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_GAP, S_START, S_WAIT, S_DLY, S_NEXT, S_DONE, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]   idx_q, idx_d;
  logic            start_q, start_d;
  logic [DW-1:0]   data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   entry;
  logic            is_delay;
  logic [31:0]     elapsed;

  // Table entry currently addressed by reg_index
  always_comb begin
    entry = '1;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx_q == IW'(i)) entry = INIT_TABLE[i*DW +: DW];
    end
  end

  assign is_delay = (entry[DW-1 -: 8] == DELAY_TAG);
  // Cycles spent in the current state including this one
  assign elapsed  = 32'(cnt_q) + 32'd1;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_PWRUP: begin
        if (elapsed >= DELAY_TIME) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP: begin
        if (elapsed >= GAP_CYCLES) begin
          if (is_delay) begin
            state_d = S_DLY;
            cnt_d   = CW'(entry[DLY_W-1:0]);
          end else begin
            state_d = S_START;
            start_d = 1'b1;
            data_d  = entry;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A finish on the final timeout cycle takes priority over the error
        if (spi_finish) begin
          state_d = S_NEXT;
          data_d  = '1;
        end else if ((TIMEOUT != 0) && (elapsed >= TIMEOUT)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          data_d  = '1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DLY: begin
        if (cnt_q <= CW'(1)) state_d = S_NEXT;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_NEXT: begin
        cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_GAP;
          idx_d   = idx_q + IW'(1);
        end
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          state_d = S_GAP;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_PWRUP;
    endcase
    busy_d = !((state_d == S_DONE) || (state_d == S_ERR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign spi_start   = start_q;
  assign spi_data    = data_q;
  assign reg_index   = idx_q;
  assign busy        = busy_q;
  assign config_done = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_spi_init_seq.sv
// Bench for spi_init_seq: directed scenario table, hand-written corner sequences
// and randomized finish latencies checked against an event-time reference model.
module tb_spi_init_seq;

  localparam int unsigned DW         = 16;
  localparam int unsigned NREGS      = 3;
  localparam int unsigned DELAY_TIME = 10;
  localparam int unsigned GAP        = 4;
  localparam int unsigned TMO        = 50;
  localparam logic [47:0] TABLE      = 48'h0C07_FF05_0E00;
  localparam logic [7:0]  TAG        = 8'hFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             restart = 1'b0;
  logic             fin_auto = 1'b0;
  logic             fin_man = 1'b0;
  logic             spi_finish;
  logic             spi_start;
  logic [DW-1:0]    spi_data;
  logic [1:0]       reg_index;
  logic             busy, config_done, timeout_err;

  assign spi_finish = fin_auto | fin_man;

  spi_init_seq #(
    .DATA_WIDTH(DW), .NUM_REGS(NREGS), .INIT_TABLE(TABLE), .DELAY_TIME(DELAY_TIME),
    .GAP_CYCLES(GAP), .TIMEOUT(TMO), .DELAY_TAG(TAG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .spi_finish(spi_finish),
    .spi_start(spi_start), .spi_data(spi_data), .reg_index(reg_index),
    .busy(busy), .config_done(config_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
      $fatal(1, "watchdog");
    end
  end

  typedef struct { int unsigned t; logic [DW-1:0] d; } start_t;
  start_t      start_log[$];
  int unsigned lat_q[$];
  bit          auto_en = 1'b1;
  bit          pend = 1'b0;
  int unsigned due = 0;

  // Start monitor and auto-responder: finish arrives L edges after each start (L=0: withheld)
  always @(negedge clk) begin
    int unsigned lat;
    if (!rst_n) begin
      pend     = 1'b0;
      fin_auto = 1'b0;
    end else begin
      if (pend && cyc == due) begin
        fin_auto = 1'b0;
        pend     = 1'b0;
      end
      if (spi_start) begin
        start_log.push_back('{cyc, spi_data});
        if (auto_en) begin
          lat = (lat_q.size() > 0) ? lat_q.pop_front() : 8;
          if (lat != 0) begin
            pend = 1'b1;
            due  = cyc + lat;
          end
        end
      end
      if (pend && cyc + 1 == due) fin_auto = 1'b1;
    end
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned base = 0;

  int unsigned   m_t[$];
  logic [DW-1:0] m_d[$];
  int unsigned   m_end;
  bit            m_err;
  logic [1:0]    m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, 32'(spi_start), 32'd0);
    chk({tag, "_data"},  32'(spi_data), 32'h0000_FFFF);
    chk({tag, "_idx"},   32'(reg_index), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd1);
    chk({tag, "_done"},  32'(config_done), 32'd0);
    chk({tag, "_err"},   32'(timeout_err), 32'd0);
  endtask

  // Asynchronous assert mid-cycle, then release on a falling edge; base marks release
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    repeat (3) @(negedge clk);
    check_reset_vals("rst_held");
    lat_q.delete();
    start_log.delete();
    rst_n = 1'b1;
    base  = cyc;
  endtask

  task automatic wait_to(input int unsigned rel);
    while (cyc - base < rel) @(negedge clk);
  endtask

  // Event-time model: edge offsets from base for each start and for the final status
  task automatic predict(input bit via_rst, input int unsigned l0, input int unsigned l1);
    int unsigned t, lat, k, n;
    logic [47:0] tbl;
    logic [DW-1:0] e;
    tbl = TABLE;
    m_t.delete();
    m_d.delete();
    m_err = 1'b0;
    m_idx = 2'(NREGS - 1);
    t = via_rst ? DELAY_TIME : 1;
    k = 0;
    for (int i = 0; i < int'(NREGS); i++) begin
      e = tbl[i*DW +: DW];
      t += GAP;
      if (e[DW-1 -: 8] == TAG) begin
        n = 32'(e[DW-9:0]);
        t += ((n == 0) ? 1 : n) + 1;
      end else begin
        m_t.push_back(t);
        m_d.push_back(e);
        lat = (k == 0) ? l0 : l1;
        k++;
        if (lat == 0 || lat > TMO + 1) begin
          m_err = 1'b1;
          m_idx = 2'(i);
          m_end = t + TMO + 1;
          return;
        end
        t += lat + 1;
      end
    end
    m_end = t;
  endtask

  task automatic run_seq(input bit via_rst, input bit spurious, input int unsigned l0,
                         input int unsigned l1, output int unsigned t_end);
    if (via_rst) begin
      do_reset();
    end else begin
      @(negedge clk);
      start_log.delete();
      lat_q.delete();
      restart = 1'b1;
      base    = cyc;
    end
    lat_q.push_back(l0);
    lat_q.push_back(l1);
    t_end = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      restart = 1'b0;
      if (!busy) begin
        t_end = cyc - base;
        break;
      end
      if (spurious && $urandom_range(0, 7) == 0) restart = 1'b1;
    end
    restart = 1'b0;
    if (t_end == 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: busy still 1 after 1000 cycles, expected completion");
    end
  endtask

  task automatic check_outcome(input string tag, input int unsigned t_end);
    int unsigned n;
    chk({tag, "_nstarts"}, 32'(start_log.size()), 32'(m_t.size()));
    n = (start_log.size() < m_t.size()) ? start_log.size() : m_t.size();
    for (int i = 0; i < int'(n); i++) begin
      chk({tag, "_start_t"}, start_log[i].t - base, m_t[i]);
      chk({tag, "_start_d"}, 32'(start_log[i].d), 32'(m_d[i]));
    end
    chk({tag, "_end_t"}, t_end, m_end);
    chk({tag, "_done"},  32'(config_done), 32'(!m_err));
    chk({tag, "_err"},   32'(timeout_err), 32'(m_err));
    chk({tag, "_idx"},   32'(reg_index), 32'(m_idx));
    chk({tag, "_data"},  32'(spi_data), 32'h0000_FFFF);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  task automatic quiet_check(input string tag);
    repeat (60) @(negedge clk);
    chk({tag, "_no_extra_start"}, 32'(start_log.size()), 32'(m_t.size()));
  endtask

  function automatic int unsigned pick_lat();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 6) return $urandom_range(2, 51);
    if (r == 7) return 51;
    if (r == 8) return 52;
    return 0;
  endfunction

  typedef struct {
    bit            via_rst;
    int unsigned   lat0, lat1;
    int unsigned   n_st;
    int unsigned   t0;
    logic [DW-1:0] d0;
    int unsigned   t1;
    logic [DW-1:0] d1;
    int unsigned   t_end;
    bit            err;
    logic [1:0]    idx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int unsigned t_end;
    bit via;
    int unsigned l0, l1;

    vecs[0] = '{1'b1, 8,  8,  2, 14, 16'h0E00, 37, 16'h0C07, 46,  1'b0, 2'd2};
    vecs[1] = '{1'b1, 0,  8,  1, 14, 16'h0E00, 0,  16'h0000, 65,  1'b1, 2'd0};
    vecs[2] = '{1'b0, 8,  8,  2, 5,  16'h0E00, 28, 16'h0C07, 37,  1'b0, 2'd2};
    vecs[3] = '{1'b0, 8,  52, 2, 5,  16'h0E00, 28, 16'h0C07, 79,  1'b1, 2'd2};
    vecs[4] = '{1'b0, 51, 51, 2, 5,  16'h0E00, 71, 16'h0C07, 123, 1'b0, 2'd2};
    vecs[5] = '{1'b0, 2,  2,  2, 5,  16'h0E00, 22, 16'h0C07, 25,  1'b0, 2'd2};

    // Bring-up with finish withheld so the first table row resets mid-WAIT
    do_reset();
    lat_q.push_back(0);
    wait_to(20);
    chk("pre_nstarts", 32'(start_log.size()), 32'd1);
    if (start_log.size() > 0) begin
      chk("pre_start_t", start_log[0].t - base, 32'd14);
      chk("pre_start_d", 32'(start_log[0].d), 32'h0E00);
    end
    chk("pre_wait_data", 32'(spi_data), 32'h0E00);
    chk("pre_wait_busy", 32'(busy), 32'd1);

    foreach (vecs[i]) begin
      run_seq(vecs[i].via_rst, 1'b0, vecs[i].lat0, vecs[i].lat1, t_end);
      m_t.delete();
      m_d.delete();
      m_t.push_back(vecs[i].t0);
      m_d.push_back(vecs[i].d0);
      if (vecs[i].n_st > 1) begin
        m_t.push_back(vecs[i].t1);
        m_d.push_back(vecs[i].d1);
      end
      m_end = vecs[i].t_end;
      m_err = vecs[i].err;
      m_idx = vecs[i].idx;
      check_outcome($sformatf("row%0d", i), t_end);
      quiet_check($sformatf("row%0d", i));
    end

    // Finish pulses in GAP and on the START cycle must be ignored
    auto_en = 1'b0;
    @(negedge clk);
    start_log.delete();
    lat_q.delete();
    restart = 1'b1;
    base    = cyc;
    @(negedge clk);
    restart = 1'b0;
    wait_to(2);  fin_man = 1'b1;
    wait_to(3);  fin_man = 1'b0;
    wait_to(5);  fin_man = 1'b1;
    wait_to(6);  fin_man = 1'b0;
    chk("t4_nstarts", 32'(start_log.size()), 32'd1);
    chk("t4_idx_after_start", 32'(reg_index), 32'd0);
    chk("t4_data_after_start", 32'(spi_data), 32'h0E00);
    chk("t4_busy", 32'(busy), 32'd1);
    wait_to(20);
    chk("t4_data_hold", 32'(spi_data), 32'h0E00);
    chk("t4_idx_hold", 32'(reg_index), 32'd0);
    chk("t4_no_err", 32'(timeout_err), 32'd0);
    chk("t4_nstarts_hold", 32'(start_log.size()), 32'd1);
    fin_man = 1'b1;
    auto_en = 1'b1;
    wait_to(21);
    fin_man = 1'b0;
    chk("t4_data_released", 32'(spi_data), 32'h0000_FFFF);
    t_end = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        t_end = cyc - base;
        break;
      end
    end
    m_t.delete();
    m_d.delete();
    m_t.push_back(5);  m_d.push_back(16'h0E00);
    m_t.push_back(36); m_d.push_back(16'h0C07);
    m_end = 45;
    m_err = 1'b0;
    m_idx = 2'd2;
    check_outcome("t4", t_end);

    // Random latencies with ignored restart pulses while busy
    for (int it = 0; it < 25; it++) begin
      via = ($urandom_range(0, 4) == 0);
      l0  = pick_lat();
      l1  = pick_lat();
      predict(via, l0, l1);
      run_seq(via, 1'b1, l0, l1, t_end);
      check_outcome($sformatf("rnd%0d", it), t_end);
      if (m_err) quiet_check($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
